// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad conditioner
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } key_state_t;

  localparam int DIGIT_W_DEF         = 4;
  localparam int MAX_DIGIT           = 9;
  localparam int GLITCH_MAX          = 15;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/keypad_conditioner_sync_2ff.sv
// rtl/keypad_conditioner_sync_2ff.sv - two-flop synchronizer, resets to zero
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_conditioner.sv
// rtl/keypad_conditioner.sv - synchronize/debounce enter key, capture digit per press
// Optional digit range check enabled by defining KEYPAD_DIGIT_RANGE_CHECK_EN.
module keypad_conditioner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int DIGIT_W         = DIGIT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               enter_raw,
  input  logic [DIGIT_W-1:0] digit_raw,
  output logic               enter_pulse,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               key_held,
  output logic               invalid_pulse,
  output logic [3:0]         glitch_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic               enter_s;
  logic [DIGIT_W-1:0] digit_s;
  key_state_t         state, state_d;
  logic [CW-1:0]      cnt, cnt_d;
  logic               accept;
  logic               abort;
  logic               digit_ok;

  sync_2ff #(.WIDTH(1)) u_sync_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (enter_raw),
    .q     (enter_s)
  );

  sync_2ff #(.WIDTH(DIGIT_W)) u_sync_digit (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (digit_raw),
    .q     (digit_s)
  );

`ifdef KEYPAD_DIGIT_RANGE_CHECK_EN
  assign digit_ok = (digit_s <= DIGIT_W'(MAX_DIGIT));
`else
  assign digit_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    accept  = 1'b0;
    abort   = 1'b0;
    if (!ena) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (enter_s) begin
            state_d = PRESS_DB;
            cnt_d   = '0;
          end
        end
        PRESS_DB: begin
          if (!enter_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            abort   = 1'b1;
          end else if (cnt == CNT_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            accept  = 1'b1;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        HELD: begin
          if (!enter_s) begin
            state_d = REL_DB;
            cnt_d   = '0;
          end
        end
        REL_DB: begin
          // a high sample here is release bounce: back to HELD without a new pulse
          if (enter_s) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_pulse   <= 1'b0;
      invalid_pulse <= 1'b0;
      digit_out     <= '0;
      glitch_count  <= '0;
    end else begin
      enter_pulse   <= accept & digit_ok;
      invalid_pulse <= accept & ~digit_ok;
      if (accept && digit_ok) begin
        digit_out <= digit_s;
      end
      if (abort && glitch_count != 4'(GLITCH_MAX)) begin
        glitch_count <= glitch_count + 4'd1;
      end
    end
  end

  assign key_held = (state == HELD) || (state == REL_DB);

endmodule

// File: tb/tb_keypad_conditioner.sv
// tb/tb_keypad_conditioner.sv - randomized and directed bench with run-length reference model
module tb_keypad_conditioner;

  localparam int D = 4;
`ifdef KEYPAD_DIGIT_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       enter_raw = 1'b0;
  logic [3:0] digit_raw = 4'd0;
  logic       enter_pulse;
  logic [3:0] digit_out;
  logic       key_held;
  logic       invalid_pulse;
  logic [3:0] glitch_count;

  keypad_conditioner #(.DEBOUNCE_CYCLES(D), .DIGIT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .enter_raw     (enter_raw),
    .digit_raw     (digit_raw),
    .enter_pulse   (enter_pulse),
    .digit_out     (digit_out),
    .key_held      (key_held),
    .invalid_pulse (invalid_pulse),
    .glitch_count  (glitch_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: synchronizer delay lines plus run lengths of the synced enter
  logic       m_e1, m_e2;
  logic [3:0] m_d1, m_d2;
  bit         pressed;
  int         hrun, lrun;
  logic       m_pulse, m_inv;
  logic [3:0] m_digit;
  int         m_glitch;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_e1 = 0; m_e2 = 0; m_d1 = 0; m_d2 = 0;
    pressed = 0; hrun = 0; lrun = 0;
    m_pulse = 0; m_inv = 0; m_digit = 0; m_glitch = 0;
  endtask

  task automatic model_step();
    logic s;
    logic [3:0] d;
    s = m_e2;
    d = m_d2;
    m_pulse = 0;
    m_inv = 0;
    if (!ena) begin
      pressed = 0; hrun = 0; lrun = 0;
    end else if (!pressed) begin
      if (s) begin
        hrun++;
        if (hrun == D + 1) begin
          pressed = 1; hrun = 0; lrun = 0;
          if (RC && d > 9) m_inv = 1;
          else begin m_pulse = 1; m_digit = d; end
        end
      end else begin
        if (hrun > 0 && m_glitch < 15) m_glitch++;
        hrun = 0;
      end
    end else begin
      if (!s) begin
        lrun++;
        if (lrun == D + 1) begin pressed = 0; lrun = 0; end
      end else lrun = 0;
    end
    m_e2 = m_e1; m_e1 = enter_raw;
    m_d2 = m_d1; m_d1 = digit_raw;
  endtask

  task automatic check_all();
    chk("enter_pulse", 8'(enter_pulse), 8'(m_pulse));
    chk("invalid_pulse", 8'(invalid_pulse), 8'(m_inv));
    chk("digit_out", 8'(digit_out), 8'(m_digit));
    chk("key_held", 8'(key_held), 8'(pressed));
    chk("glitch_count", 8'(glitch_count), 8'(m_glitch));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ticks until a pulse appears; the first tick is the first edge sampling the input
  task automatic wait_pulse(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (enter_pulse || invalid_pulse) begin n = i; break; end
    end
  endtask

  task automatic release_key();
    enter_raw = 0;
    ticks(D + 8);
  endtask

  int n;
  int g0;
  logic [3:0] dprev;

  initial begin
    model_reset();
    #1;
    check_all();
    ticks(3);
    rst_n = 1; ena = 1;
    ticks(3);

    // clean press with digit 7, held long
    digit_raw = 4'h7; ticks(3);
    enter_raw = 1;
    wait_pulse(n);
    chk("clean_latency", 8'(n), 8'(D + 3));
    chk("clean_digit", 8'(digit_out), 8'h7);
    ticks(50);
    chk("clean_held", 8'(key_held), 8'd1);
    release_key();
    chk("clean_released", 8'(key_held), 8'd0);

    // press bounce: high 2, low 1, then steady
    g0 = glitch_count;
    enter_raw = 1; ticks(2);
    enter_raw = 0; tick();
    enter_raw = 1;
    wait_pulse(n);
    chk("bounce_latency", 8'(n), 8'(D + 3));
    chk("bounce_glitch", 8'(glitch_count), 8'(g0 + 1));
    ticks(20);
    release_key();

    // release bounce, then next press still works
    enter_raw = 1; wait_pulse(n); ticks(5);
    enter_raw = 0; ticks(2);
    enter_raw = 1; tick();
    enter_raw = 0; ticks(3);
    chk("relbounce_held", 8'(key_held), 8'd1);
    ticks(D + 6);
    chk("relbounce_idle", 8'(key_held), 8'd0);
    enter_raw = 1; wait_pulse(n);
    chk("relbounce_next", 8'(n), 8'(D + 3));
    release_key();

    // digit change while held
    digit_raw = 4'h3; ticks(3);
    enter_raw = 1; wait_pulse(n);
    digit_raw = 4'h5; ticks(10);
    chk("digit_hold", 8'(digit_out), 8'h3);
    release_key();
    enter_raw = 1; wait_pulse(n);
    chk("digit_next", 8'(digit_out), 8'h5);
    release_key();

    // reset mid-press at cnt==2
    enter_raw = 1; ticks(5);
    #1 rst_n = 0;
    #1;
    model_reset();
    chk("rst_pulse", 8'(enter_pulse), 8'd0);
    chk("rst_held", 8'(key_held), 8'd0);
    chk("rst_digit", 8'(digit_out), 8'd0);
    chk("rst_glitch", 8'(glitch_count), 8'd0);
    ticks(2);
    rst_n = 1;
    wait_pulse(n);
    chk("rst_latency", 8'(n), 8'(D + 3));
    release_key();

    // out-of-range digit
    dprev = digit_out;
    digit_raw = 4'hC; ticks(3);
    enter_raw = 1; wait_pulse(n);
    if (RC) begin
      chk("range_inv", 8'(invalid_pulse), 8'd1);
      chk("range_enter", 8'(enter_pulse), 8'd0);
      chk("range_digit", 8'(digit_out), 8'(dprev));
    end else begin
      chk("range_enter", 8'(enter_pulse), 8'd1);
      chk("range_digit", 8'(digit_out), 8'hC);
    end
    tick();
    chk("range_onecycle", 8'(enter_pulse | invalid_pulse), 8'd0);
    release_key();

    // randomized bursts, digit changes and enable drops
    for (int k = 0; k < 600; k++) begin
      enter_raw = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) digit_raw = 4'($urandom_range(0, 15));
      ena = ($urandom_range(0, 29) != 0);
      ticks($urandom_range(1, 10));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
